fphub_sqrt_arbiter: RTL

FPHUB_SQRT_ARBITER -- requirements
Module: fphub_sqrt_arbiter

---
 rtl/fphub_pkg.sv | 19 +
 rtl/fphub_rr_pick.sv | 35 +++
 rtl/fphub_sqrt_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fphub_pkg.sv
// Shared definitions for the square-root hub arbiter: default float field widths,
// bus width helper and the arbiter FSM state encoding.
package fphub_pkg;

  localparam int M_DEFAULT = 23;
  localparam int E_DEFAULT = 8;

  function automatic int fp_width(input int m, input int e);
    return m + e + 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/fphub_rr_pick.sv
// Round-robin picker: grants the first asserted request at or above the pointer,
// wrapping around, and reports the winner's index.
module fphub_rr_pick
  import fphub_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest asserted request wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    sum   = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum  = {1'b0, ptr_i} + (IW+1)'(k);
      cand = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
      if (req_i[cand]) begin
        gnt_o       = '0;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/fphub_sqrt_arbiter.sv
// Arbitrates NREQ requesters onto one external square-root unit, one operation at a time,
// with a watchdog on the unit's done pulse.
//   state    | meaning
//   ST_IDLE  | offer round-robin grant, latch operand and id on handshake
//   ST_ISSUE | pulse sq_start once the unit is not busy
//   ST_WAIT  | wait for sq_finish or watchdog expiry
//   ST_RESP  | hold response until rsp_ready
module fphub_sqrt_arbiter
  import fphub_pkg::*;
#(
  parameter  int M       = M_DEFAULT,
  parameter  int E       = E_DEFAULT,
  parameter  int NREQ    = 4,
  parameter  int TIMEOUT = 64,
  localparam int W       = fp_width(M, E),
  localparam int IW      = $clog2(NREQ),
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_x,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IW-1:0]     rsp_id,
  output logic [W-1:0]      rsp_res,
  output logic              rsp_err,
  output logic              sq_start,
  output logic [W-1:0]      sq_x,
  input  logic [W-1:0]      sq_res,
  input  logic              sq_finish,
  input  logic              sq_computing
);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  op_q, op_d;
  logic [IW-1:0] id_q, id_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  res_q, res_d;
  logic          err_q, err_d;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gidx;
  logic            accept;

  fphub_rr_pick #(.N(NREQ)) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx)
  );

  // Grant is masked by reset so req_ready reads zero while rst_l is low.
  assign req_ready = (state_q == ST_IDLE && rst_l) ? gnt : '0;
  assign accept    = |(req_valid & req_ready);
  assign sq_start  = (state_q == ST_ISSUE) && !sq_computing;
  assign sq_x      = op_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = id_q;
  assign rsp_res   = res_q;
  assign rsp_err   = err_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    op_d    = op_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = req_x[gidx*W +: W];
          id_d    = gidx;
          ptr_d   = (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!sq_computing) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A done pulse on the last watchdog cycle still counts as a result.
        if (sq_finish) begin
          res_d   = sq_res;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      op_q    <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

endmodule
